// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchroniser plus per-bit counter debounce for slide switches
//
// Purpose: condition raw board switch levels before they reach the CPU SW inputs.
//   Each bit is synchronised to clk and only allowed to change its clean level
//   after db_cycles consecutive cycles of disagreement with the current clean level.
//
// Optional feature macro: SW_EDGE_PULSE_EN (adds the sw_rise port and its registers).
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   sw_raw      raw asynchronous switch levels
//   sw_clean    debounced levels
//   sw_changed  one-cycle pulse when any sw_clean bit changes
//   sw_rise     per-bit one-cycle rising-edge pulses (SW_EDGE_PULSE_EN only)

module sw_debounce #(
  parameter int n_sw      = 10,
  parameter int db_cycles = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [n_sw-1:0] sw_raw,
  output logic [n_sw-1:0] sw_clean,
  output logic            sw_changed
`ifdef SW_EDGE_PULSE_EN
  ,
  output logic [n_sw-1:0] sw_rise
`endif
);

  // max(1, $clog2(db_cycles)); db_cycles of 1 or 2 still needs a 1-bit counter.
  localparam int cnt_w = (db_cycles > 2) ? $clog2(db_cycles) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(db_cycles - 1);

  logic [n_sw-1:0]  sync1;
  logic [n_sw-1:0]  sync2;
  logic [cnt_w-1:0] cnt [n_sw];
  logic [n_sw-1:0]  flip;

  // A bit flips when it has disagreed with its clean level for db_cycles
  // consecutive cycles, i.e. this is the db_cycles-th disagreeing cycle.
  always_comb begin
    flip = '0;
    for (int i = 0; i < n_sw; i++) begin
      flip[i] = (sync2[i] != sw_clean[i]) && (cnt[i] == cnt_last);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Counter clears on agreement or on qualification, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < n_sw; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < n_sw; i++) begin
        if ((sync2[i] == sw_clean[i]) || flip[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_clean   <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_clean   <= sw_clean ^ flip;
      sw_changed <= |flip;
    end
  end

`ifdef SW_EDGE_PULSE_EN
  // A flipping bit takes the sync2 value, so flip & sync2 marks 0->1 updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_rise <= '0;
    end else begin
      sw_rise <= flip & sync2;
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed self-checking bench for sw_debounce (n_sw=10, db_cycles=4)

module tb_sw_debounce;

  logic       clk;
  logic       reset;
  logic [9:0] sw_raw;
  logic [9:0] sw_clean;
  logic       sw_changed;
`ifdef SW_EDGE_PULSE_EN
  logic [9:0] sw_rise;
`endif

  int checks;
  int failures;

  sw_debounce #(
    .n_sw      (10),
    .db_cycles (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .sw_changed (sw_changed)
`ifdef SW_EDGE_PULSE_EN
    ,
    .sw_rise    (sw_rise)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [9:0] v);
    sw_raw = v;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    logic [9:0] exp_clean;
    logic       exp_chg;
    checks++;
    if (sw_clean !== 10'h000) begin
      failures++; $display("FAIL reset_init_clean got=%h exp=%h", sw_clean, 10'h000);
    end
    checks++;
    if (sw_changed !== 1'b0) begin
      failures++; $display("FAIL reset_init_changed got=%b exp=0", sw_changed);
    end
    sw_raw = 10'h3FF;
    reset  = 1'b0;
    repeat (10) tick();
    checks++;
    if (sw_clean !== 10'h3FF) begin
      failures++; $display("FAIL reset_pre_clean got=%h exp=%h", sw_clean, 10'h3FF);
    end
    // Asynchronous assertion between edges must clear outputs immediately.
    #2 reset = 1'b1;
    #1;
    checks++;
    if (sw_clean !== 10'h000) begin
      failures++; $display("FAIL reset_async_clean got=%h exp=%h", sw_clean, 10'h000);
    end
    checks++;
    if (sw_changed !== 1'b0) begin
      failures++; $display("FAIL reset_async_changed got=%b exp=0", sw_changed);
    end
`ifdef SW_EDGE_PULSE_EN
    checks++;
    if (sw_rise !== 10'h000) begin
      failures++; $display("FAIL reset_async_rise got=%h exp=%h", sw_rise, 10'h000);
    end
`endif
    #1 reset = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      exp_clean = (j >= 5) ? 10'h3FF : 10'h000;
      exp_chg   = (j == 5);
      checks++;
      if (sw_clean !== exp_clean) begin
        failures++; $display("FAIL reset_rel_clean j=%0d got=%h exp=%h", j, sw_clean, exp_clean);
      end
      checks++;
      if (sw_changed !== exp_chg) begin
        failures++; $display("FAIL reset_rel_changed j=%0d got=%b exp=%b", j, sw_changed, exp_chg);
      end
    end
  endtask

  task automatic test_single_press();
    logic [9:0] exp_clean;
    logic       exp_chg;
    settle(10'h000);
    sw_raw = 10'h008;
    for (int j = 0; j < 8; j++) begin
      tick();
      exp_clean = (j >= 5) ? 10'h008 : 10'h000;
      exp_chg   = (j == 5);
      checks++;
      if (sw_clean !== exp_clean) begin
        failures++; $display("FAIL press_clean j=%0d got=%h exp=%h", j, sw_clean, exp_clean);
      end
      checks++;
      if (sw_changed !== exp_chg) begin
        failures++; $display("FAIL press_changed j=%0d got=%b exp=%b", j, sw_changed, exp_chg);
      end
`ifdef SW_EDGE_PULSE_EN
      checks++;
      if (sw_rise !== ((j == 5) ? 10'h008 : 10'h000)) begin
        failures++; $display("FAIL press_rise j=%0d got=%h exp=%h", j, sw_rise, (j == 5) ? 10'h008 : 10'h000);
      end
`endif
    end
  endtask

  task automatic test_glitch();
    logic exp_b0;
    logic exp_chg;
    settle(10'h000);
    // Three-cycle pulse: filtered out.
    for (int j = 0; j < 12; j++) begin
      sw_raw = (j < 3) ? 10'h001 : 10'h000;
      tick();
      checks++;
      if (sw_clean !== 10'h000 || sw_changed !== 1'b0) begin
        failures++; $display("FAIL glitch3 j=%0d clean=%h changed=%b exp clean=000 changed=0", j, sw_clean, sw_changed);
      end
    end
    // Four-cycle pulse: passes, and falls back only after four stable low cycles.
    for (int j = 0; j < 14; j++) begin
      sw_raw = (j < 4) ? 10'h001 : 10'h000;
      tick();
      exp_b0  = (j >= 5 && j <= 8);
      exp_chg = (j == 5 || j == 9);
      checks++;
      if (sw_clean !== {9'h000, exp_b0}) begin
        failures++; $display("FAIL glitch4_clean j=%0d got=%h exp=%h", j, sw_clean, {9'h000, exp_b0});
      end
      checks++;
      if (sw_changed !== exp_chg) begin
        failures++; $display("FAIL glitch4_changed j=%0d got=%b exp=%b", j, sw_changed, exp_chg);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [9:0] exp_clean;
    logic       exp_chg;
    settle(10'h000);
    sw_raw = 10'h201;
    for (int j = 0; j < 8; j++) begin
      tick();
      exp_clean = (j >= 5) ? 10'h201 : 10'h000;
      exp_chg   = (j == 5);
      checks++;
      if (sw_clean !== exp_clean) begin
        failures++; $display("FAIL simul_clean j=%0d got=%h exp=%h", j, sw_clean, exp_clean);
      end
      checks++;
      if (sw_changed !== exp_chg) begin
        failures++; $display("FAIL simul_changed j=%0d got=%b exp=%b", j, sw_changed, exp_chg);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_clean;
    logic       exp_chg;
    settle(10'h000);
    for (int j = 0; j < 9; j++) begin
      sw_raw = (j == 0) ? 10'h001 : 10'h003;
      tick();
      exp_clean = (j < 5) ? 10'h000 : ((j == 5) ? 10'h001 : 10'h003);
      exp_chg   = (j == 5 || j == 6);
      checks++;
      if (sw_clean !== exp_clean) begin
        failures++; $display("FAIL stagger_clean j=%0d got=%h exp=%h", j, sw_clean, exp_clean);
      end
      checks++;
      if (sw_changed !== exp_chg) begin
        failures++; $display("FAIL stagger_changed j=%0d got=%b exp=%b", j, sw_changed, exp_chg);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [9:0] exp_clean;
    logic       exp_chg;
    settle(10'h000);
    sw_raw = 10'h200;
    repeat (5) tick();
    checks++;
    if (sw_clean !== 10'h000) begin
      failures++; $display("FAIL midcount_pre got=%h exp=%h", sw_clean, 10'h000);
    end
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      exp_clean = (j >= 5) ? 10'h200 : 10'h000;
      exp_chg   = (j == 5);
      checks++;
      if (sw_clean !== exp_clean) begin
        failures++; $display("FAIL midcount_clean j=%0d got=%h exp=%h", j, sw_clean, exp_clean);
      end
      checks++;
      if (sw_changed !== exp_chg) begin
        failures++; $display("FAIL midcount_changed j=%0d got=%b exp=%b", j, sw_changed, exp_chg);
      end
    end
  endtask

  task automatic test_falling();
    logic [9:0] exp_clean;
    logic       exp_chg;
    settle(10'h020);
    checks++;
    if (sw_clean !== 10'h020) begin
      failures++; $display("FAIL fall_pre got=%h exp=%h", sw_clean, 10'h020);
    end
    sw_raw = 10'h000;
    for (int j = 0; j < 8; j++) begin
      tick();
      exp_clean = (j >= 5) ? 10'h000 : 10'h020;
      exp_chg   = (j == 5);
      checks++;
      if (sw_clean !== exp_clean) begin
        failures++; $display("FAIL fall_clean j=%0d got=%h exp=%h", j, sw_clean, exp_clean);
      end
      checks++;
      if (sw_changed !== exp_chg) begin
        failures++; $display("FAIL fall_changed j=%0d got=%b exp=%b", j, sw_changed, exp_chg);
      end
`ifdef SW_EDGE_PULSE_EN
      checks++;
      if (sw_rise !== 10'h000) begin
        failures++; $display("FAIL fall_rise j=%0d got=%h exp=%h", j, sw_rise, 10'h000);
      end
`endif
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    sw_raw   = 10'h000;
    repeat (2) tick();
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_count();
    test_falling();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
